// File: rtl/fp16_normalize_if.sv
// Handshake bundle for the fp16 post-add normalizer: operand side (in_*) and result side (out_*).
interface fp16_normalize_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sign;
    logic [EXP_W-1:0]       in_exp;
    logic [MAN_W+1:0]       in_sum;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   out_result;
    logic                   out_ovf;
    logic                   out_unf;

    modport master (
        output in_valid, in_sign, in_exp, in_sum, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_sum, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_unf
    );
endinterface

// File: rtl/fp16_normalize.sv
// Post-add normalizer: one-bit right shift on carry, iterative left shift to the hidden bit, flush-to-zero.
// Define FP16_NORM_ROUND_EN to round the carry right-shift to nearest-even instead of truncating.
module fp16_normalize #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    fp16_normalize_if.slave       bus
);
    localparam int RES_W = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W:0] EXP_ONE  = (EXP_W+1)'(1);
    localparam logic [EXP_W:0] EXP_ONES = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [EXP_W:0]     exp_q, exp_d;
    logic [MAN_W+1:0]   sum_q, sum_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    // Carry path: fraction and exponent after the one-bit right shift (and optional rounding).
    logic [MAN_W-1:0]   rnd_frac;
    logic [EXP_W:0]     rnd_exp;
`ifdef FP16_NORM_ROUND_EN
    logic               rnd_cy;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            sum_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        sum_d    = sum_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        rnd_frac = sum_q[MAN_W:1];
        rnd_exp  = exp_q + EXP_ONE;
`ifdef FP16_NORM_ROUND_EN
        rnd_cy   = 1'b0;
        // Hidden bit is always set after the carry shift, so a fraction carry means mantissa overflow.
        if (sum_q[1] && sum_q[0]) begin
            {rnd_cy, rnd_frac} = {1'b0, rnd_frac} + (MAN_W+1)'(1);
            if (rnd_cy) begin
                rnd_exp = rnd_exp + EXP_ONE;
            end
        end
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.in_sign;
                    exp_d   = {1'b0, bus.in_exp};
                    sum_d   = bus.in_sum;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (sum_q == '0 || exp_q == '0) begin
                    result_d = {sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    state_d  = DONE;
                end else if (sum_q[MAN_W+1]) begin
                    if (rnd_exp >= EXP_ONES) begin
                        result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
                        ovf_d    = 1'b0;
                    end
                    unf_d   = 1'b0;
                    state_d = DONE;
                end else if (sum_q[MAN_W]) begin
                    result_d = {sign_q, exp_q[EXP_W-1:0], sum_q[MAN_W-1:0]};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    state_d  = DONE;
                end else if (exp_q == EXP_ONE) begin
                    result_d = {sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    sum_d = {sum_q[MAN_W:0], 1'b0};
                    exp_d = exp_q - EXP_ONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = result_q;
    assign bus.out_ovf    = ovf_q;
    assign bus.out_unf    = unf_q;
endmodule
